// File: rtl/alarm_pkg.sv
// Shared types for the alarm sequencer: FSM state encoding and BCD digit widths.
package alarm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    RINGING = 3'd2,
    SNOOZE  = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int H1W = 2;
  localparam int H2W = 4;
  localparam int M1W = 3;
  localparam int M2W = 4;

endpackage

// File: rtl/hhmm_match.sv
// Compares current HH:MM against the alarm HH:MM and flags the rising edge of
// equality as a trigger, suppressed while the user is adjusting.
module hhmm_match
  import alarm_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           adjust_i,
  input  logic [H1W-1:0] t_h1_i,
  input  logic [H2W-1:0] t_h2_i,
  input  logic [M1W-1:0] t_m1_i,
  input  logic [M2W-1:0] t_m2_i,
  input  logic [H1W-1:0] a_h1_i,
  input  logic [H2W-1:0] a_h2_i,
  input  logic [M1W-1:0] a_m1_i,
  input  logic [M2W-1:0] a_m2_i,
  output logic           match_o,
  output logic           trigger_o
);

  logic match_q;

  assign match_o = (t_h1_i == a_h1_i) && (t_h2_i == a_h2_i) &&
                   (t_m1_i == a_m1_i) && (t_m2_i == a_m2_i);

  // match_q keeps tracking during adjust so releasing adjust mid-minute cannot fire.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) match_q <= 1'b0;
    else         match_q <= match_o;
  end

  assign trigger_o = match_o & ~match_q & ~adjust_i;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm runtime control: arming, triggering, ring cadence, snooze, dismiss and
// auto-silence; drives the buzzer and status indications from registered state.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int RING_S     = 60,
  parameter int SNOOZE_S   = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick_2hz,
  input  logic           alarm_en,
  input  logic           adjust,
  input  logic           snooze_p,
  input  logic           dismiss_p,
  input  logic [H1W-1:0] t_h1,
  input  logic [H2W-1:0] t_h2,
  input  logic [M1W-1:0] t_m1,
  input  logic [M2W-1:0] t_m2,
  input  logic [H1W-1:0] a_h1,
  input  logic [H2W-1:0] a_h2,
  input  logic [M1W-1:0] a_m1,
  input  logic [M2W-1:0] a_m2,
  output logic           buzz,
  output logic           led,
  output logic           ringing,
  output logic           snoozing,
  output logic [1:0]     snooze_cnt
);

  localparam int TMAX = (RING_S > SNOOZE_S) ? RING_S : SNOOZE_S;
  localparam int TW   = $clog2(TMAX + 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          half_q, half_d;
  logic          buzz_q, led_q, ring_q, snz_q;
  logic          match, trigger, sec_tick;

  hhmm_match u_match (
    .clk_i    (clk),
    .rst_ni   (rst),
    .adjust_i (adjust),
    .t_h1_i   (t_h1),
    .t_h2_i   (t_h2),
    .t_m1_i   (t_m1),
    .t_m2_i   (t_m2),
    .a_h1_i   (a_h1),
    .a_h2_i   (a_h2),
    .a_m1_i   (a_m1),
    .a_m2_i   (a_m2),
    .match_o  (match),
    .trigger_o(trigger)
  );

  assign sec_tick = tick_2hz & half_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    phase_d = 1'b0;
    half_d  = half_q ^ tick_2hz;
    if (!alarm_en) begin
      state_d = IDLE;
      timer_d = '0;
      cnt_d   = '0;
    end else if (adjust && (state_q == RINGING || state_q == SNOOZE)) begin
      state_d = DONE;
    end else begin
      case (state_q)
        IDLE:  state_d = ARMED;
        ARMED: begin
          if (trigger) begin
            state_d = RINGING;
            timer_d = '0;
            phase_d = 1'b1;
          end
        end
        RINGING: begin
          phase_d = phase_q ^ tick_2hz;
          if (dismiss_p) begin
            state_d = DONE;
          end else if (snooze_p) begin
            if (cnt_q < 2'(MAX_SNOOZE)) begin
              state_d = SNOOZE;
              cnt_d   = cnt_q + 2'd1;
              timer_d = TW'(SNOOZE_S);
            end else begin
              state_d = DONE;
            end
          end else if (sec_tick) begin
            if (timer_q == TW'(RING_S - 1)) state_d = DONE;
            else                            timer_d = timer_q + 1'b1;
          end
        end
        SNOOZE: begin
          if (dismiss_p) begin
            state_d = DONE;
          end else if (sec_tick) begin
            if (timer_q == TW'(1)) begin
              state_d = RINGING;
              timer_d = '0;
              phase_d = 1'b1;
            end else begin
              timer_d = timer_q - 1'b1;
            end
          end
        end
        DONE: begin
          cnt_d   = '0;
          timer_d = '0;
          if (!match) state_d = ARMED;
        end
        default: state_d = IDLE;
      endcase
    end
    // Restart the half-second phase so every ring/snooze period starts on a whole second.
    if ((state_d == RINGING || state_d == SNOOZE) && state_d != state_q) half_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      half_q  <= 1'b0;
      buzz_q  <= 1'b0;
      led_q   <= 1'b0;
      ring_q  <= 1'b0;
      snz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      half_q  <= half_d;
      buzz_q  <= (state_d == RINGING) & phase_d;
      led_q   <= (state_d == ARMED) | (state_d == SNOOZE) | ((state_d == RINGING) & phase_d);
      ring_q  <= (state_d == RINGING);
      snz_q   <= (state_d == SNOOZE);
    end
  end

  assign buzz       = buzz_q;
  assign led        = led_q;
  assign ringing    = ring_q;
  assign snoozing   = snz_q;
  assign snooze_cnt = cnt_q;

endmodule
